serial_pe_ctrl: RTL and testbench

Sequencer for one serial MAC processing element (the PE). It computes a fully-connected layer: out_num output neurons, each the dot product of a vec_len-element input vector and its own weight row. It streams neuron/weight pairs from two synchronous read buffers into the PE and drives the PE's first/last control bits. It captures each finished PE result into an output buffer and signals completion to the layer-level controller.

---
 rtl/serial_pe_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_pe_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pe_ctrl.sv
// Sequencer for one serial MAC PE: streams neuron/weight pairs, drives PE first/last, captures results.
// Optional build macro RELU_EN clamps negative results to zero before the output buffer write.
module serial_pe_ctrl #(
    parameter int DATA_W = 16,
    parameter int RES_W  = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic [LEN_W-1:0]  out_num,
    output logic              busy,
    output logic              done,
    output logic              nbuf_rd,
    output logic [ADDR_W-1:0] nbuf_addr,
    input  logic [DATA_W-1:0] nbuf_data,
    output logic              wbuf_rd,
    output logic [ADDR_W-1:0] wbuf_addr,
    input  logic [DATA_W-1:0] wbuf_data,
    output logic [DATA_W-1:0] pe_neuron,
    output logic [DATA_W-1:0] pe_weight,
    output logic [1:0]        pe_ctl,
    output logic              pe_vld,
    input  logic [RES_W-1:0]  pe_result,
    input  logic              pe_vld_o,
    output logic              obuf_wr,
    output logic [ADDR_W-1:0] obuf_addr,
    output logic [RES_W-1:0]  obuf_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t state, state_nx;

    logic [LEN_W-1:0]  len_q, num_q;
    logic [LEN_W-1:0]  i_cnt, o_cnt, wr_cnt;
    logic [ADDR_W-1:0] w_cnt, wr_addr;
    logic              issue, is_first, is_last, last_issue, accept, capture;
    logic [RES_W-1:0]  res_val;

    assign accept     = (state == IDLE) && start;
    assign issue      = (state == ISSUE);
    assign is_first   = (i_cnt == '0);
    assign is_last    = (i_cnt == len_q - LEN_W'(1));
    assign last_issue = issue && is_last && (o_cnt == num_q - LEN_W'(1));
    // A stray PE result outside a job must not disturb the write counter.
    assign capture    = pe_vld_o && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = (vec_len == '0 || out_num == '0) ? DONE : ISSUE;
            ISSUE: if (last_issue) state_nx = DRAIN;
            DRAIN: if (wr_cnt == num_q) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign nbuf_rd   = issue;
    assign wbuf_rd   = issue;
    assign nbuf_addr = ADDR_W'(i_cnt);
    assign wbuf_addr = w_cnt;
    assign pe_neuron = nbuf_data;
    assign pe_weight = wbuf_data;

    // Issue counters; the weight address is a free-running linear count, not o*vec_len+i.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q <= '0;
            num_q <= '0;
            i_cnt <= '0;
            o_cnt <= '0;
            w_cnt <= '0;
        end else if (accept) begin
            len_q <= vec_len;
            num_q <= out_num;
            i_cnt <= '0;
            o_cnt <= '0;
            w_cnt <= '0;
        end else if (issue) begin
            w_cnt <= w_cnt + ADDR_W'(1);
            if (is_last) begin
                i_cnt <= '0;
                if (!last_issue) o_cnt <= o_cnt + LEN_W'(1);
            end else begin
                i_cnt <= i_cnt + LEN_W'(1);
            end
        end
    end

    // Read data returns one cycle after the read, so the control bits are delayed to match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pe_vld <= 1'b0;
            pe_ctl <= 2'b00;
        end else begin
            pe_vld <= issue;
            pe_ctl <= issue ? {is_last, is_first} : 2'b00;
        end
    end

`ifdef RELU_EN
    assign res_val = pe_result[RES_W-1] ? '0 : pe_result;
`else
    assign res_val = pe_result;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            obuf_wr   <= 1'b0;
            obuf_addr <= '0;
            obuf_data <= '0;
            wr_cnt    <= '0;
            wr_addr   <= '0;
        end else begin
            obuf_wr <= capture;
            if (accept) begin
                wr_cnt  <= '0;
                wr_addr <= '0;
            end else if (capture) begin
                obuf_addr <= wr_addr;
                obuf_data <= res_val;
                wr_cnt    <= wr_cnt + LEN_W'(1);
                wr_addr   <= wr_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_pe_ctrl.sv
// Directed, table-driven bench for serial_pe_ctrl with behavioural buffers and a serial MAC PE.
module tb_serial_pe_ctrl;

    localparam int DATA_W = 16;
    localparam int RES_W  = 32;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  vec_len = '0, out_num = '0;
    logic              busy, done, nbuf_rd, wbuf_rd, pe_vld, obuf_wr;
    logic [ADDR_W-1:0] nbuf_addr, wbuf_addr, obuf_addr;
    logic [DATA_W-1:0] nbuf_data, wbuf_data, pe_neuron, pe_weight;
    logic [1:0]        pe_ctl;
    logic [RES_W-1:0]  pe_result, obuf_data;
    logic              pe_vld_o;

    serial_pe_ctrl #(.DATA_W(DATA_W), .RES_W(RES_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .out_num(out_num),
        .busy(busy), .done(done),
        .nbuf_rd(nbuf_rd), .nbuf_addr(nbuf_addr), .nbuf_data(nbuf_data),
        .wbuf_rd(wbuf_rd), .wbuf_addr(wbuf_addr), .wbuf_data(wbuf_data),
        .pe_neuron(pe_neuron), .pe_weight(pe_weight), .pe_ctl(pe_ctl), .pe_vld(pe_vld),
        .pe_result(pe_result), .pe_vld_o(pe_vld_o),
        .obuf_wr(obuf_wr), .obuf_addr(obuf_addr), .obuf_data(obuf_data)
    );

    always #5 clk = ~clk;

    // Buffers and PE model
    logic [DATA_W-1:0] nmem [64];
    logic [DATA_W-1:0] wmem [64];
    logic signed [RES_W-1:0] psum;

    always @(posedge clk) begin
        if (nbuf_rd) nbuf_data <= nmem[nbuf_addr[5:0]];
        if (wbuf_rd) wbuf_data <= wmem[wbuf_addr[5:0]];
    end

    always @(posedge clk) begin
        logic signed [RES_W-1:0] prod, nxt;
        if (!rst_n) begin
            psum      <= '0;
            pe_result <= '0;
            pe_vld_o  <= 1'b0;
        end else begin
            prod = RES_W'($signed(pe_neuron) * $signed(pe_weight));
            nxt  = pe_ctl[0] ? prod : psum + prod;
            pe_vld_o <= pe_vld && pe_ctl[1];
            if (pe_vld) begin
                psum      <= nxt;
                pe_result <= nxt;
            end
        end
    end

    // Monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nrd, nctl, nwr, done_cnt, done_cyc, bfirst, blast;
    bit bseen;
    int rd_na [64];
    int rd_wa [64];
    logic [1:0]  ctl_log [64];
    logic [31:0] wr_a [64];
    logic [31:0] wr_d [64];

    always @(negedge clk) begin
        if (nbuf_rd && nrd < 64) begin
            rd_na[nrd] = int'(nbuf_addr);
            rd_wa[nrd] = int'(wbuf_addr);
            nrd++;
        end
        if (pe_vld && nctl < 64) begin
            ctl_log[nctl] = pe_ctl;
            nctl++;
        end
        if (obuf_wr && nwr < 64) begin
            wr_a[nwr] = 32'(obuf_addr);
            wr_d[nwr] = obuf_data;
            nwr++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) begin
            if (!bseen) bfirst = cyc;
            bseen = 1'b1;
            blast = cyc;
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        nrd = 0; nctl = 0; nwr = 0; done_cnt = 0; done_cyc = -1; bseen = 1'b0; bfirst = -1; blast = -1;
    endtask

    task automatic fill_mem(input int nbase, input int wbase);
        for (int k = 0; k < 64; k++) begin
            nmem[k] = DATA_W'(nbase + k);
            wmem[k] = DATA_W'(wbase + k);
        end
    endtask

    typedef struct {
        int                vl;
        int                on;
        int                nbase;
        int                wbase;
        logic [2:0][31:0]  res;
        logic [5:0][1:0]   ctl;
    } vec_t;

    localparam logic [31:0] NEG_RES =
`ifdef RELU_EN
        32'h0000_0000;
`else
        32'hFFFF_FFFC;
`endif

    vec_t vecs [6];

    // Runs one job; optional second start mid-job with different lengths.
    task automatic run_job(input int vl, input int on, input bit restart, output int s);
        clear_logs();
        @(negedge clk);
        start = 1'b1; vec_len = LEN_W'(vl); out_num = LEN_W'(on);
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        if (restart) begin
            @(negedge clk);
            start = 1'b1; vec_len = LEN_W'(2); out_num = LEN_W'(5);
            @(negedge clk);
            start = 1'b0;
        end
        for (int t = 0; t < 200 && done_cnt == 0; t++) @(negedge clk);
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL done_timeout actual=0 expected=1");
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic check_job(input string tag, input vec_t v, input int s);
        int l, nw, bad;
        l  = v.vl * v.on;
        nw = (l > 0) ? v.on : 0;
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_cyc"}, 32'(done_cyc - s), (l > 0) ? 32'(l + 4) : 32'd1);
        chk({tag, "_busy_first"}, 32'(bfirst - s), 32'd1);
        chk({tag, "_busy_last"}, 32'(blast - s), (l > 0) ? 32'(l + 4) : 32'd1);
        chk({tag, "_reads"}, 32'(nrd), 32'(l));
        chk({tag, "_pe_vld"}, 32'(nctl), 32'(l));
        chk({tag, "_writes"}, 32'(nwr), 32'(nw));
        bad = 0;
        for (int j = 0; j < nrd && j < l; j++)
            if (rd_na[j] != j % v.vl || rd_wa[j] != j) bad++;
        chk({tag, "_addr_seq"}, 32'(bad), 32'd0);
        for (int j = 0; j < nctl && j < 6; j++)
            chk({tag, "_pe_ctl"}, 32'(ctl_log[j]), 32'(v.ctl[j]));
        for (int j = 0; j < nwr && j < 3; j++) begin
            chk({tag, "_obuf_addr"}, wr_a[j], 32'(j));
            chk({tag, "_obuf_data"}, wr_d[j], v.res[j]);
        end
    endtask

    initial begin
        int s;
        vecs[0] = '{vl:4, on:1, nbase:1,  wbase:5, res:{32'd0, 32'd0, 32'd70},
                    ctl:{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01}};
        vecs[1] = '{vl:3, on:2, nbase:1,  wbase:5, res:{32'd0, 32'd56, 32'd38},
                    ctl:{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01}};
        vecs[2] = '{vl:1, on:3, nbase:1,  wbase:5, res:{32'd7, 32'd6, 32'd5},
                    ctl:{2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11}};
        vecs[3] = '{vl:1, on:1, nbase:-2, wbase:2, res:{32'd0, 32'd0, NEG_RES},
                    ctl:{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11}};
        vecs[4] = '{vl:0, on:3, nbase:1,  wbase:5, res:'0, ctl:'0};
        vecs[5] = '{vl:2, on:0, nbase:1,  wbase:5, res:'0, ctl:'0};

        clear_logs();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", {27'd0, nbuf_rd, wbuf_rd, pe_vld, obuf_wr, done}, 32'd0);
        chk("rst_addr", 32'(nbuf_addr | wbuf_addr | obuf_addr), 32'd0);
        chk("rst_obuf_data", obuf_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            fill_mem(vecs[k].nbase, vecs[k].wbase);
            run_job(vecs[k].vl, vecs[k].on, 1'b0, s);
            check_job($sformatf("vec%0d", k), vecs[k], s);
        end

        // Start re-pulsed mid-job must not disturb the running job.
        fill_mem(1, 5);
        run_job(4, 1, 1'b1, s);
        check_job("restart", vecs[0], s);

        // Reset in the middle of ISSUE aborts cleanly.
        clear_logs();
        @(negedge clk);
        start = 1'b1; vec_len = LEN_W'(4); out_num = LEN_W'(2);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outs", {27'd0, busy, nbuf_rd, wbuf_rd, pe_vld, obuf_wr}, 32'd0);
        chk("abort_ctl", 32'(pe_ctl), 32'd0);
        chk("abort_addr", 32'(nbuf_addr | wbuf_addr | obuf_addr), 32'd0);
        chk("abort_obuf_data", obuf_data, 32'd0);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (10) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_no_write", 32'(nwr), 32'd0);

        run_job(4, 1, 1'b0, s);
        check_job("post_rst", vecs[0], s);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
